// File: rtl/registerfile_pkg.sv
// Shared definitions for the multi-port register file and its bench.
//   RF_WIDTH / RF_DEPTH / RF_ZERO_REG : default geometry (64-bit x 32, r31 = 0)
//   rf_addr_w()                       : address width for a given depth
package registerfile_pkg;

    localparam int RF_WIDTH    = 64;
    localparam int RF_DEPTH    = 32;
    localparam int RF_ZERO_REG = 31;

    function automatic int rf_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/registerfile_mp_if.sv
// Bus between decode/writeback and the register file.
//   select / out / busy             : NREAD read ports (flattened, port r at slice r)
//   write / address / data_in       : NWRITE write ports (flattened)
//   reserve / reserve_address       : scoreboard reservation from issue
// master = decode/writeback side, slave = register file.
interface registerfile_mp_if
    import registerfile_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int ADDR_W = rf_addr_w(DEPTH);

    logic [NREAD*ADDR_W-1:0]  select;
    logic [NREAD*WIDTH-1:0]   out;
    logic [NREAD-1:0]         busy;
    logic [NWRITE-1:0]        write;
    logic [NWRITE*ADDR_W-1:0] address;
    logic [NWRITE*WIDTH-1:0]  data_in;
    logic                     reserve;
    logic [ADDR_W-1:0]        reserve_address;

    modport master (
        output select, write, address, data_in, reserve, reserve_address,
        input  out, busy
    );

    modport slave (
        input  select, write, address, data_in, reserve, reserve_address,
        output out, busy
    );

endinterface

// File: rtl/registerfile_mp_read_port.sv
// One combinational read port of the register file.
//   sel_i                          : register index to read
//   regs_i / pend_i                : current array contents and pending bits
//   wr_en_i / wr_addr_i / wr_data_i: this cycle's write ports (for forwarding)
//   data_o / busy_o                : read data and pending status
module registerfile_read_port
    import registerfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = rf_addr_w(DEPTH)
) (
    input  logic [ADDR_W-1:0]        sel_i,
    input  logic [WIDTH-1:0]         regs_i [DEPTH],
    input  logic [DEPTH-1:0]         pend_i,
    input  logic [NWRITE-1:0]        wr_en_i,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr_i,
    input  logic [NWRITE*WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     busy_o
);
    localparam bit               HAS_ZERO  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    always_comb begin
        data_o = regs_i[sel_i];
        busy_o = pend_i[sel_i];
        // Ascending scan: the highest-numbered matching write port wins.
        for (int w = 0; w < NWRITE; w++) begin
            if ((BYPASS != 0) && wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == sel_i)) begin
                data_o = wr_data_i[w*WIDTH +: WIDTH];
                busy_o = 1'b0;
            end
        end
        // The zero register reads as 0 even when a write to it is in flight.
        if (HAS_ZERO && (sel_i == ZERO_ADDR)) begin
            data_o = '0;
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/registerfile_mp.sv
// Parametrised multi-port register file with write-pending scoreboard.
//   clock / reset : single clock, synchronous active-high reset
//   rf (slave)    : read ports, write ports and reservation input
// Holds the register array and pending bits; read ports are instantiated
// NREAD times from registerfile_read_port.
module registerfile_mp
    import registerfile_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1
) (
    input  logic               clock,
    input  logic               reset,
    registerfile_mp_if.slave   rf
);
    localparam int ADDR_W = rf_addr_w(DEPTH);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic [WIDTH-1:0] rd_data [NREAD];
    logic             rd_busy [NREAD];

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            // Later write ports overwrite earlier ones: port 1 wins collisions.
            for (int w = 0; w < NWRITE; w++) begin
                if (rf.write[w] && (rf.address[w*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                    regs_d[i] = rf.data_in[w*WIDTH +: WIDTH];
                    pend_d[i] = 1'b0;
                end
            end
            // A new reservation supersedes a completing write to the same register.
            if (rf.reserve && (rf.reserve_address == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end
            if (i == ZERO_REG) begin
                regs_d[i] = '0;
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    for (genvar r = 0; r < NREAD; r++) begin : g_rd
        registerfile_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .NWRITE   (NWRITE),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS),
            .ADDR_W   (ADDR_W)
        ) u_rd (
            .sel_i     (rf.select[r*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .pend_i    (pend_q),
            .wr_en_i   (rf.write),
            .wr_addr_i (rf.address),
            .wr_data_i (rf.data_in),
            .data_o    (rd_data[r]),
            .busy_o    (rd_busy[r])
        );
    end

    always_comb begin
        rf.out  = '0;
        rf.busy = '0;
        for (int r = 0; r < NREAD; r++) begin
            rf.out[r*WIDTH +: WIDTH] = rd_data[r];
            rf.busy[r]               = rd_busy[r];
        end
    end

endmodule

// File: tb/tb_registerfile_mp.sv
module tb_registerfile_mp;
    import registerfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ab = 1'b1;
    logic rst_c  = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    registerfile_mp_if #(.WIDTH(RF_WIDTH), .DEPTH(RF_DEPTH), .NREAD(2), .NWRITE(2)) ifa ();
    registerfile_mp_if #(.WIDTH(RF_WIDTH), .DEPTH(RF_DEPTH), .NREAD(2), .NWRITE(2)) ifb ();
    registerfile_mp_if #(.WIDTH(32), .DEPTH(16), .NREAD(4), .NWRITE(2)) ifc ();

    registerfile_mp #(.BYPASS(1)) dut_a (.clock(clk), .reset(rst_ab), .rf(ifa));
    registerfile_mp #(.BYPASS(0)) dut_b (.clock(clk), .reset(rst_ab), .rf(ifb));
    registerfile_mp #(.WIDTH(32), .DEPTH(16), .NREAD(4), .NWRITE(2), .ZERO_REG(15), .BYPASS(1))
        dut_c (.clock(clk), .reset(rst_c), .rf(ifc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic w0, input logic w1,
                          input logic [4:0] a0, input logic [4:0] a1,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input logic res, input logic [4:0] ra,
                          input logic [4:0] s0, input logic [4:0] s1);
        ifa.write = {w1, w0}; ifa.address = {a1, a0}; ifa.data_in = {d1, d0};
        ifa.reserve = res; ifa.reserve_address = ra; ifa.select = {s1, s0};
        ifb.write = {w1, w0}; ifb.address = {a1, a0}; ifb.data_in = {d1, d0};
        ifb.reserve = res; ifb.reserve_address = ra; ifb.select = {s1, s0};
        #2;
    endtask

    task automatic idle(input logic [4:0] s0, input logic [4:0] s1);
        set_ab(0, 0, 5'd0, 5'd0, 64'd0, 64'd0, 0, 5'd0, s0, s1);
    endtask

    // Reference model for the 32-bit/16-entry/4-read instance.
    logic [31:0] mem [16];
    logic        pend [16];

    initial begin
        ifc.write = '0; ifc.address = '0; ifc.data_in = '0;
        ifc.reserve = 1'b0; ifc.reserve_address = '0; ifc.select = '0;

        // Write issued during reset must not survive.
        rst_ab = 1'b1;
        set_ab(1, 0, 5'd5, 5'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 1, 5'd6, 5'd5, 5'd6);
        tick();
        rst_ab = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            chk("rst A out0", ifa.out[63:0], 64'd0);
            chk("rst A out1", ifa.out[127:64], 64'd0);
            chk("rst A busy", {62'd0, ifa.busy}, 64'd0);
            chk("rst B out0", ifb.out[63:0], 64'd0);
            chk("rst B out1", ifb.out[127:64], 64'd0);
            chk("rst B busy", {62'd0, ifb.busy}, 64'd0);
        end

        // Same-cycle forwarding vs. old value.
        set_ab(1, 0, 5'd5, 5'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 0, 5'd0, 5'd0, 5'd5);
        chk("fwd A r5", ifa.out[127:64], 64'hDEAD_BEEF_0000_0001);
        chk("nofwd B r5", ifb.out[127:64], 64'd0);
        tick();
        idle(5'd0, 5'd5);
        chk("stored A r5", ifa.out[127:64], 64'hDEAD_BEEF_0000_0001);
        chk("stored B r5", ifb.out[127:64], 64'hDEAD_BEEF_0000_0001);

        // Write collision: port 1 wins.
        set_ab(1, 1, 5'd7, 5'd7, 64'h11, 64'h22, 0, 5'd0, 5'd7, 5'd0);
        chk("coll fwd A", ifa.out[63:0], 64'h22);
        chk("coll B old", ifb.out[63:0], 64'd0);
        tick();
        idle(5'd7, 5'd5);
        chk("coll store A", ifa.out[63:0], 64'h22);
        chk("coll store B", ifb.out[63:0], 64'h22);

        // Zero register.
        set_ab(1, 0, 5'd31, 5'd0, 64'hFFFF, 64'd0, 0, 5'd0, 5'd31, 5'd0);
        chk("zero fwd A", ifa.out[63:0], 64'd0);
        tick();
        set_ab(0, 0, 5'd0, 5'd0, 64'd0, 64'd0, 1, 5'd31, 5'd31, 5'd31);
        chk("zero rd A", ifa.out[63:0], 64'd0);
        chk("zero rd B", ifb.out[63:0], 64'd0);
        tick();
        idle(5'd31, 5'd31);
        chk("zero busy A", {63'd0, ifa.busy[0]}, 64'd0);
        chk("zero busy B", {63'd0, ifb.busy[0]}, 64'd0);

        // Reserve r3, busy from next cycle, cleared by write.
        set_ab(0, 0, 5'd0, 5'd0, 64'd0, 64'd0, 1, 5'd3, 5'd3, 5'd0);
        chk("res N A", {63'd0, ifa.busy[0]}, 64'd0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            idle(5'd3, 5'd0);
            chk($sformatf("res N+%0d A", k), {63'd0, ifa.busy[0]}, 64'd1);
            chk($sformatf("res N+%0d B", k), {63'd0, ifb.busy[0]}, 64'd1);
            tick();
        end
        set_ab(1, 0, 5'd3, 5'd0, 64'h33, 64'd0, 0, 5'd0, 5'd3, 5'd0);
        chk("wr N+4 busy A", {63'd0, ifa.busy[0]}, 64'd0);
        chk("wr N+4 busy B", {63'd0, ifb.busy[0]}, 64'd1);
        chk("wr N+4 out A", ifa.out[63:0], 64'h33);
        tick();
        idle(5'd3, 5'd0);
        chk("after wr busy A", {63'd0, ifa.busy[0]}, 64'd0);
        chk("after wr busy B", {63'd0, ifb.busy[0]}, 64'd0);
        chk("after wr out B", ifb.out[63:0], 64'h33);

        // Reserve and write together: reservation wins.
        set_ab(0, 1, 5'd0, 5'd3, 64'd0, 64'h44, 1, 5'd3, 5'd3, 5'd0);
        tick();
        idle(5'd3, 5'd0);
        chk("res+wr busy A", {63'd0, ifa.busy[0]}, 64'd1);
        chk("res+wr busy B", {63'd0, ifb.busy[0]}, 64'd1);
        chk("res+wr out A", ifa.out[63:0], 64'h44);

        // Reset clears data and pending.
        rst_ab = 1'b1;
        idle(5'd3, 5'd5);
        tick();
        rst_ab = 1'b0;
        idle(5'd3, 5'd5);
        chk("rst2 busy A", {62'd0, ifa.busy}, 64'd0);
        chk("rst2 out A", ifa.out[63:0], 64'd0);
        chk("rst2 r5 B", ifb.out[127:64], 64'd0);

        // Randomized run on the 32x16, 4-read instance.
        tick();
        rst_c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            logic        we [2];
            logic [3:0]  wa [2];
            logic [31:0] wd [2];
            logic        res;
            logic [3:0]  ra;
            logic [3:0]  sel [4];
            logic        rr;
            logic [31:0] e_out;
            logic        e_busy;

            rr  = ($urandom_range(0, 99) == 0);
            res = ($urandom_range(0, 3) == 0);
            ra  = 4'($urandom_range(0, 15));
            for (int w = 0; w < 2; w++) begin
                we[w] = ($urandom_range(0, 1) == 1);
                wa[w] = 4'($urandom_range(0, 15));
                wd[w] = $urandom;
                ifc.write[w]         = we[w];
                ifc.address[w*4 +: 4] = wa[w];
                ifc.data_in[w*32 +: 32] = wd[w];
            end
            for (int r = 0; r < 4; r++) begin
                sel[r] = 4'($urandom_range(0, 15));
                ifc.select[r*4 +: 4] = sel[r];
            end
            ifc.reserve = res;
            ifc.reserve_address = ra;
            rst_c = rr;
            #2;
            for (int r = 0; r < 4; r++) begin
                if (sel[r] == 4'd15) begin
                    e_out = 32'd0; e_busy = 1'b0;
                end else if (we[1] && wa[1] == sel[r]) begin
                    e_out = wd[1]; e_busy = 1'b0;
                end else if (we[0] && wa[0] == sel[r]) begin
                    e_out = wd[0]; e_busy = 1'b0;
                end else begin
                    e_out = mem[sel[r]]; e_busy = pend[sel[r]];
                end
                chk($sformatf("C out%0d cyc%0d", r, cyc), {32'd0, ifc.out[r*32 +: 32]}, {32'd0, e_out});
                chk($sformatf("C busy%0d cyc%0d", r, cyc), {63'd0, ifc.busy[r]}, {63'd0, e_busy});
            end
            tick();
            if (rr) begin
                for (int i = 0; i < 16; i++) begin
                    mem[i]  = '0;
                    pend[i] = 1'b0;
                end
            end else begin
                for (int w = 0; w < 2; w++) begin
                    if (we[w]) begin
                        if (wa[w] != 4'd15) mem[wa[w]] = wd[w];
                        pend[wa[w]] = 1'b0;
                    end
                end
                if (res && ra != 4'd15) pend[ra] = 1'b1;
            end
        end
        rst_c = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/registerfile_mp.md
# registerfile_mp

Parametrised multi-port register file with a write-pending scoreboard, the successor to the fixed 32 x 64-bit, 2-read/1-write `registerfile`. Width, depth, read-port count and write-port count are parameters. Same-cycle write-to-read forwarding is selectable, and one register can be hard-wired to zero. The block sits in the datapath between decode (selects, reservations) and writeback (write ports).

## Interface
Parameters:
- `WIDTH`, 64: data width in bits.
- `DEPTH`, 32: number of registers; power of two, at least 2. `ADDR_W` = $clog2(DEPTH).
- `NREAD`, 2: number of read ports, 1..4.
- `NWRITE`, 2: number of write ports, 1..2.
- `ZERO_REG`, DEPTH-1: index hard-wired to zero. A value of DEPTH or more disables the zero register.
- `BYPASS`, 1: 1 forwards same-cycle write data to reads; 0 makes reads return the old value.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `select`  in  NREAD*ADDR_W  read addresses; port r uses bits [r*ADDR_W +: ADDR_W].
- `out`  out  NREAD*WIDTH  read data; port r uses bits [r*WIDTH +: WIDTH].
- `busy`  out  NREAD  pending bit of the register selected on each read port.
- `write`  in  NWRITE  write enable per write port.
- `address`  in  NWRITE*ADDR_W  write addresses.
- `data_in`  in  NWRITE*WIDTH  write data.
- `reserve`  in  1  marks `reserve_address` as pending (a producer has issued).
- `reserve_address`  in  ADDR_W  register to reserve.

## Operation
- Reads are combinational from `select`:
  - `out[r]` = regs[select[r]].
  - If `BYPASS`=1 and some write port w has write[w]=1 with address[w]=select[r], then `out[r]` = data_in[w].
- Writes happen at the rising edge: regs[address[w]] <= data_in[w] for each w with write[w]=1.
- Write collision (both ports, same address): port 1 wins for the register update and for the forwarded value.
- Zero register:
  - Writes to `ZERO_REG` are dropped.
  - Reads of `ZERO_REG` return 0 regardless of bypass.
  - `ZERO_REG` is never pending; a reservation of it is ignored.
- Scoreboard: one pending bit per register.
  - `reserve`=1 sets pending[reserve_address] at the edge.
  - Any enabled write to an address clears its pending bit at the edge.
  - Reserve and write to the same address in the same cycle: reserve wins, and the bit ends set (a new producer supersedes the completing one).
- `busy[r]` = pending[select[r]].
  - With `BYPASS`=1, `busy[r]` is forced to 0 when a write to select[r] is present this cycle (data is being forwarded).
  - With `BYPASS`=0, `busy[r]` shows the registered bit only.
- Reset:
  - All registers clear to 0 and all pending bits clear to 0 at the edge where `reset`=1.
  - Writes and reservations in that cycle are discarded; reset dominates.
- Out-of-range addresses cannot occur because `DEPTH` is a power of two.

## Timing
- Read latency: 0 cycles (combinational).
- Write-to-read: a value written at edge N is visible through the array from cycle N+1. With `BYPASS`=1 it is also visible during the write cycle.
- Reserve-to-busy: 1 cycle. busy rises in the cycle after `reserve` is sampled.
- Write-to-busy-clear: combinationally in the write cycle if `BYPASS`=1, otherwise in the next cycle.
- Values after a reset edge, with selects at any value: `out` = 0 and `busy` = 0.
- No stall or handshake from the block itself; `busy` is advisory to the issue logic.

## Structure
- Shared package `registerfile_pkg`: defaults `RF_WIDTH`=64, `RF_DEPTH`=32, `RF_ZERO_REG`=31, and the ADDR_W helper. Both this block and its bench import it.
- Sub-module `registerfile_read_port`, instantiated NREAD times from a generate loop. It holds the array mux, bypass compare across write ports (port-1 priority), zero-register override, and the busy mask.
- The array and the pending vector live in the top module; writes use a per-register loop with port-1 priority.

## Test plan
- Reset, then read every address on both ports → all `out` = 0 and all `busy` = 0. A write issued in the same cycle as reset is absent afterwards.
- Write 0xDEADBEEF_00000001 to reg 5 on port 0 and read reg 5 on port 1 in the same cycle → with `BYPASS`=1, out = DEADBEEF_00000001 that cycle. With `BYPASS`=0, out = 0 that cycle and the new value the next cycle.
- Both write ports target reg 7 with 0x11 (port 0) and 0x22 (port 1) → forwarded and stored value = 0x22.
- Write 0xFFFF to reg 31, then read reg 31 → out = 0. Reserve reg 31 → busy stays 0.
- Reserve reg 3 at cycle N → busy = 1 from N+1. Write reg 3 at cycle N+4 → busy = 0 in cycle N+4 (`BYPASS`=1). Reserve and write reg 3 in the same cycle → busy = 1 afterwards.
- Build with WIDTH=32, DEPTH=16, NREAD=4 and run random writes/reads against a reference-model array → zero mismatches over 1000 cycles.
